// File: rtl/pattern_detect_controller_if.sv
// Configuration port of pattern_detect_controller: valid/ready handshake carrying
// pattern, length and target, plus the reject pulse back to the host.
interface pattern_detect_controller_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/pattern_detect_controller.sv
// Run-time configurable serial pattern detector with arm/disarm control.
// Overlapping matches are counted; done is raised when a nonzero target is reached.
module pattern_detect_controller #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    pattern_detect_controller_if.slave cfg,
    input  logic                      arm,
    input  logic                      disarm,
    input  logic                      a_valid,
    input  logic                      a,
    output logic                      detected,
    output logic [CNT_W-1:0]          match_count,
    output logic                      busy,
    output logic                      done
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic               cfg_loaded;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   target_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic               cfg_err_q;

    logic               cfg_hs;
    logic               cfg_ok;
    logic               idle_or_done;
    logic               sample;
    logic               arm_go;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic               reached;
    logic               match;
    logic [CNT_W-1:0]   count_next;
    logic               target_hit;

    // ------------------------------------------------------------------
    // Decode of this cycle's control and scan conditions
    // ------------------------------------------------------------------
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign cfg_hs       = cfg.cfg_valid && idle_or_done;
    assign cfg_ok       = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));

    // A config handshake in the same cycle takes precedence over arm.
    assign arm_go = arm && !disarm && cfg_loaded && idle_or_done && !cfg_hs;
    // Samples arriving with disarm are dropped together with any match they make.
    assign sample = a_valid && !disarm && ((state == ST_FILL) || (state == ST_RUN));

    assign hist_next = {hist[MAX_LEN-2:0], a};
    assign fill_inc  = {1'b0, fill} + (LEN_W + 1)'(1);
    assign reached   = fill_inc >= {1'b0, len_q};

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path can leave it holding a value (no inferred latch).
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign match = sample && reached && (((hist_next ^ pattern_q) & len_mask) == '0);

    always_comb begin
        count_next = match_count;
        if (match && (match_count != '1)) begin
            count_next = match_count + CNT_W'(1);
        end
    end

    assign target_hit = match && (target_q != '0) && (count_next == target_q);

    // ------------------------------------------------------------------
    // Control FSM: state register, next-state logic, state-decoded outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (disarm) begin
            state_next = ST_IDLE;
        end else if (arm_go) begin
            state_next = ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    if (target_hit) begin
                        state_next = ST_DONE;
                    end else if (sample && reached) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (target_hit) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        cfg.cfg_ready = idle_or_done;
        busy          = (state == ST_FILL) || (state == ST_RUN);
        done          = (state == ST_DONE);
    end

    assign cfg.cfg_err = cfg_err_q;

    // ------------------------------------------------------------------
    // Configuration, history and match counting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the history shift register is small and must read as a clean
        // all-zero window after reset, so it is reset like any other flop.
        if (rst) begin
            cfg_loaded  <= 1'b0;
            pattern_q   <= '0;
            len_q       <= '0;
            target_q    <= '0;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            detected    <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            detected  <= match;
            cfg_err_q <= cfg_hs && !cfg_ok;

            if (cfg_hs && cfg_ok) begin
                cfg_loaded <= 1'b1;
                pattern_q  <= cfg.cfg_pattern;
                len_q      <= cfg.cfg_len;
                target_q   <= cfg.cfg_target;
            end

            if (arm_go) begin
                hist        <= '0;
                fill        <= '0;
                match_count <= '0;
            end else if (sample) begin
                hist        <= hist_next;
                fill        <= reached ? len_q : fill_inc[LEN_W-1:0];
                match_count <= count_next;
            end
        end
    end
endmodule

// File: tb/tb_pattern_detect_controller.sv
// Directed self-checking bench for pattern_detect_controller: main instance with
// defaults plus a CNT_W=2 instance for counter saturation.
module tb_pattern_detect_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pattern_detect_controller_if #(.MAX_LEN(8), .CNT_W(8)) cfg_bus ();
    pattern_detect_controller_if #(.MAX_LEN(8), .CNT_W(2)) cfg_bus2 ();

    logic       arm, disarm, a_valid, a;
    logic       detected, busy, done;
    logic [7:0] match_count;

    logic       arm2, disarm2, a_valid2, a2;
    logic       detected2, busy2, done2;
    logic [1:0] match_count2;

    pattern_detect_controller #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_bus.slave),
        .arm         (arm),
        .disarm      (disarm),
        .a_valid     (a_valid),
        .a           (a),
        .detected    (detected),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    pattern_detect_controller #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_bus2.slave),
        .arm         (arm2),
        .disarm      (disarm2),
        .a_valid     (a_valid2),
        .a           (a2),
        .detected    (detected2),
        .match_count (match_count2),
        .busy        (busy2),
        .done        (done2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len,
                        input logic [7:0] tgt, input logic with_arm);
        cfg_bus.cfg_valid   = 1'b1;
        cfg_bus.cfg_pattern = pat;
        cfg_bus.cfg_len     = len;
        cfg_bus.cfg_target  = tgt;
        arm                 = with_arm;
        step();
        cfg_bus.cfg_valid = 1'b0;
        arm               = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        step();
        disarm = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_det, input string tag);
        a_valid = 1'b1;
        a       = b;
        step();
        a_valid = 1'b0;
        check(tag, detected, exp_det);
    endtask

    initial begin
        logic [5:0] s1;
        logic [9:0] s2;

        arm = 0; disarm = 0; a_valid = 0; a = 0;
        arm2 = 0; disarm2 = 0; a_valid2 = 0; a2 = 0;
        cfg_bus.cfg_valid = 0; cfg_bus.cfg_pattern = '0; cfg_bus.cfg_len = '0; cfg_bus.cfg_target = '0;
        cfg_bus2.cfg_valid = 0; cfg_bus2.cfg_pattern = '0; cfg_bus2.cfg_len = '0; cfg_bus2.cfg_target = '0;

        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_det", detected, 0);
        check("rst_count", match_count, 0);
        check("rst_ready", cfg_bus.cfg_ready, 1);
        check("rst_err", cfg_bus.cfg_err, 0);

        // Illegal lengths are rejected with a one-cycle error; arm without config ignored
        load(8'h00, 4'd0, 8'd0, 1'b0);
        check("len0_err", cfg_bus.cfg_err, 1);
        step();
        check("len0_err_pulse", cfg_bus.cfg_err, 0);
        load(8'hFF, 4'd9, 8'd1, 1'b0);
        check("len9_err", cfg_bus.cfg_err, 1);
        do_arm();
        check("noload_arm_busy", busy, 0);
        check("noload_arm_ready", cfg_bus.cfg_ready, 1);

        // len=4 pattern 1010, run forever, overlapping matches
        load(8'b0000_1010, 4'd4, 8'd0, 1'b0);
        check("t1_cfg_err", cfg_bus.cfg_err, 0);
        do_arm();
        check("t1_arm_busy", busy, 1);
        check("t1_arm_ready", cfg_bus.cfg_ready, 0);
        s1 = 6'b101010;
        for (int i = 5; i >= 0; i--) send(s1[i], (i == 2) || (i == 0), "t1_det");
        check("t1_count", match_count, 2);
        check("t1_busy", busy, 1);
        check("t1_done", done, 0);

        // Disarm keeps the count
        do_disarm();
        check("disarm_busy", busy, 0);
        check("disarm_count", match_count, 2);

        // len=6 pattern 110011 target 2; config with arm in same cycle ignores the arm
        load(8'b0011_0011, 4'd6, 8'd2, 1'b1);
        check("t2_cfg_arm_busy", busy, 0);
        do_arm();
        check("t2_arm_count_clr", match_count, 0);
        s2 = 10'b1100110011;
        for (int i = 9; i >= 0; i--) send(s2[i], (i == 4) || (i == 0), "t2_det");
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_ready", cfg_bus.cfg_ready, 1);
        check("t2_count", match_count, 2);
        send(1'b1, 1'b0, "t2_done_ignores_a");

        // Same as first case with idle cycles between samples; loaded from DONE
        load(8'b0000_1010, 4'd4, 8'd0, 1'b0);
        do_arm();
        check("t3_arm_busy", busy, 1);
        for (int i = 5; i >= 0; i--) begin
            send(s1[i], (i == 2) || (i == 0), "t3_det");
            for (int g = 0; g < 3; g++) begin
                a = ~s1[i];
                step();
                check("t3_gap_det", detected, 0);
            end
        end
        check("t3_count", match_count, 2);

        // Arm and disarm together: disarm wins
        do_disarm();
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        check("armdis_busy", busy, 0);

        // Match in the disarm cycle is dropped
        do_arm();
        s1 = 6'b101010;
        for (int i = 5; i >= 2; i--) send(s1[i], i == 2, "t6_det");
        send(1'b1, 1'b0, "t6_det5");
        a_valid = 1'b1; a = 1'b0; disarm = 1'b1;
        step();
        a_valid = 1'b0; disarm = 1'b0;
        check("t6_drop_det", detected, 0);
        check("t6_drop_count", match_count, 1);
        check("t6_drop_busy", busy, 0);

        // Asynchronous reset in RUN clears everything including the loaded config
        do_arm();
        for (int i = 5; i >= 2; i--) send(s1[i], i == 2, "t6b_det");
        #2 rst = 1'b1;
        #1;
        check("arst_det", detected, 0);
        check("arst_count", match_count, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", cfg_bus.cfg_err, 0);
        step();
        rst = 1'b0;
        do_arm();
        check("arst_arm_ignored", busy, 0);

        // CNT_W=2, len=1 pattern 1: every 1 matches, count saturates at 3
        cfg_bus2.cfg_valid   = 1'b1;
        cfg_bus2.cfg_pattern = 8'h01;
        cfg_bus2.cfg_len     = 4'd1;
        cfg_bus2.cfg_target  = 2'd0;
        step();
        cfg_bus2.cfg_valid = 1'b0;
        arm2 = 1'b1;
        step();
        arm2 = 1'b0;
        check("t5_busy", busy2, 1);
        for (int i = 0; i < 5; i++) begin
            a_valid2 = 1'b1; a2 = 1'b1;
            step();
            a_valid2 = 1'b0;
            check("t5_det", detected2, 1);
            check("t5_count", match_count2, (i < 3) ? i + 1 : 3);
        end
        a_valid2 = 1'b1; a2 = 1'b0;
        step();
        a_valid2 = 1'b0;
        check("t5_zero_det", detected2, 0);
        check("t5_sat_count", match_count2, 3);
        check("t5_done", done2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
